// File: rtl/als_pkg.sv
// Shared types and default limits for the ambient-light auto-exposure loop.
package als_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CALC,
    S_ISSUE,
    S_SETTLE
  } ae_state_t;

  localparam int AE_STEP_SHIFT = 3;
  localparam int AE_EXP_INIT   = 256;
  localparam int AE_EXP_MIN    = 16;
  localparam int AE_EXP_MAX    = 1125;

endpackage

// File: rtl/als_ae_ctrl_if.sv
// Exposure write channel between the AE controller and the sensor register writer.
interface als_ae_ctrl_if #(
  parameter int EXP_BITS = 16
);
  logic                wr_valid;
  logic                wr_ready;
  logic [EXP_BITS-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/als_luma.sv
// Registered luma estimate: mean of the four channel averages, one cycle of latency.
module als_luma #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] ch0,
  input  logic [W-1:0] ch1,
  input  logic [W-1:0] ch2,
  input  logic [W-1:0] ch3,
  output logic [W-1:0] luma
);

  // Two guard bits hold the full four-way sum.
  logic [W+1:0] sum;

  assign sum = {2'b00, ch0} + {2'b00, ch1} + {2'b00, ch2} + {2'b00, ch3};

  always_ff @(posedge clk) begin
    if (reset) luma <= '0;
    else       luma <= W'(sum >> 2);
  end

endmodule

// File: rtl/als_ae_ctrl.sv
// Auto-exposure controller: luma -> exposure step -> sensor write -> settle frames.
// Optional macro ALS_AE_SAT_FAST_EN halves exposure on a saturated channel.
module als_ae_ctrl
  import als_pkg::*;
#(
  parameter int ACCUM_OUT_BITS = 10,
  parameter int EXP_BITS       = 16,
  parameter int EXP_INIT       = AE_EXP_INIT,
  parameter int EXP_MIN        = AE_EXP_MIN,
  parameter int EXP_MAX        = AE_EXP_MAX,
  parameter int SETTLE_FRAMES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ACCUM_OUT_BITS-1:0] target,
  input  logic [ACCUM_OUT_BITS-1:0] tolerance,
  input  logic                      avg_valid,
  input  logic [ACCUM_OUT_BITS-1:0] ch0_avg,
  input  logic [ACCUM_OUT_BITS-1:0] ch1_avg,
  input  logic [ACCUM_OUT_BITS-1:0] ch2_avg,
  input  logic [ACCUM_OUT_BITS-1:0] ch3_avg,
  als_ae_ctrl_if.master             wr,
  output logic [EXP_BITS-1:0]       exposure,
  output logic                      locked,
  output logic                      busy,
  output logic [15:0]               update_count
);

  localparam int EW = EXP_BITS + 1;
  localparam logic [EW-1:0] MIN_X = EW'(EXP_MIN);
  localparam logic [EW-1:0] MAX_X = EW'(EXP_MAX);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

  ae_state_t                 state;
  logic [ACCUM_OUT_BITS-1:0] luma;
  logic [3:0]                settle_cnt;
  logic                      wr_valid_q;
  logic [EW-1:0]             exp_ext, step, dark_next, bright_next, next_ext;
  logic [ACCUM_OUT_BITS-1:0] diff;
  logic                      in_band, dark, hold;
  logic [EXP_BITS-1:0]       next_exp;

  als_luma #(.W(ACCUM_OUT_BITS)) u_luma (
    .clk   (clk),
    .reset (reset),
    .ch0   (ch0_avg),
    .ch1   (ch1_avg),
    .ch2   (ch2_avg),
    .ch3   (ch3_avg),
    .luma  (luma)
  );

`ifdef ALS_AE_SAT_FAST_EN
  logic          sat_q;
  logic          sat_now;
  logic [EW-1:0] half_next;
  assign sat_now = (&ch0_avg) | (&ch1_avg) | (&ch2_avg) | (&ch3_avg);
`endif

  // Exposure arithmetic runs one bit wider so clamping happens before truncation.
  always_comb begin
    exp_ext = {1'b0, exposure};
    step    = exp_ext >> AE_STEP_SHIFT;
    if (step == '0) step = EW'(1);
    dark_next = exp_ext + step;
    if (dark_next > MAX_X) dark_next = MAX_X;
    if (exp_ext < step + MIN_X) bright_next = MIN_X;
    else                        bright_next = exp_ext - step;
    diff    = (luma >= target) ? (luma - target) : (target - luma);
    in_band = (diff <= tolerance);
    dark    = (luma < target);
    next_ext = dark ? dark_next : bright_next;
    hold     = in_band;
`ifdef ALS_AE_SAT_FAST_EN
    half_next = exp_ext >> 1;
    if (half_next < MIN_X) half_next = MIN_X;
    if (sat_q) begin
      next_ext = half_next;
      hold     = 1'b0;
    end
`endif
    next_exp = EXP_BITS'(next_ext);
  end

  // Single control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      exposure     <= EXP_BITS'(EXP_INIT);
      wr_valid_q   <= 1'b0;
      locked       <= 1'b0;
      busy         <= 1'b0;
      update_count <= '0;
      settle_cnt   <= '0;
`ifdef ALS_AE_SAT_FAST_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (avg_valid) begin
            state <= S_CALC;
            busy  <= 1'b1;
`ifdef ALS_AE_SAT_FAST_EN
            sat_q <= sat_now;
`endif
          end
        end
        S_CALC: begin
          if (hold) begin
            locked <= 1'b1;
            state  <= S_WAIT;
            busy   <= 1'b0;
          end else begin
            locked <= 1'b0;
            if (next_exp == exposure) begin
              state <= S_WAIT;
              busy  <= 1'b0;
            end else begin
              exposure   <= next_exp;
              wr_valid_q <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (wr.wr_ready) begin
            wr_valid_q <= 1'b0;
            if (update_count != 16'hFFFF) update_count <= update_count + 16'd1;
            settle_cnt <= '0;
            if (!enable) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (SETTLE_FRAMES == 0) begin
              state <= S_WAIT;
              busy  <= 1'b0;
            end else begin
              state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (!enable) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            settle_cnt <= '0;
          end else if (avg_valid) begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= S_WAIT;
              busy       <= 1'b0;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_data  = exposure;

endmodule

// File: doc/als_ae_ctrl.md
# als_ae_ctrl

Auto-exposure controller that closes the loop around the ambient-light statistics block. It consumes the four per-channel frame averages each time they are published and forms a luma estimate from them. From that estimate it decides a new sensor exposure value and hands it to the sensor register writer over a valid/ready handshake. It then discards a programmable number of frames while the sensor settles.

## Interface
Parameters:
- `ACCUM_OUT_BITS`, 10: width of each channel average.
- `EXP_BITS`, 16: exposure value width.
- `EXP_INIT`, 256: exposure after reset.
- `EXP_MIN`, 16: lower clamp on exposure.
- `EXP_MAX`, 1125: upper clamp on exposure.
- `SETTLE_FRAMES`, 2: frames discarded after each accepted write; legal range 0..15.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: loop enable.
- `target`, in, ACCUM_OUT_BITS: desired luma.
- `tolerance`, in, ACCUM_OUT_BITS: dead-band half-width.
- `avg_valid`, in, 1: one-cycle pulse; channel averages are valid and stable from this cycle until the next pulse.
- `ch0_avg`..`ch3_avg`, in, ACCUM_OUT_BITS each: channel averages.
- `wr_valid`, out, 1: exposure write request.
- `wr_ready`, in, 1: writer accepts.
- `wr_data`, out, EXP_BITS: exposure to write; equals `exposure`.
- `exposure`, out, EXP_BITS: current exposure register.
- `locked`, out, 1: the last evaluated frame fell inside the dead-band.
- `busy`, out, 1: state is CALC, ISSUE or SETTLE.
- `update_count`, out, 16: accepted writes; saturates at 0xFFFF.

## Operation
- Luma: `luma = (ch0+ch1+ch2+ch3) >> 2`.
  - The sum is formed at ACCUM_OUT_BITS+2 bits, so it never overflows.
  - `luma` is registered.
- FSM states: IDLE, WAIT, CALC, ISSUE, SETTLE.
  - IDLE: leaves for WAIT when `enable=1`.
  - WAIT: on `avg_valid`, latch `luma` and go to CALC. On `enable=0`, go to IDLE.
  - CALC (one cycle):
    - If `|luma-target| <= tolerance`: set `locked=1`, leave `exposure` unchanged, go to WAIT.
    - Otherwise: set `locked=0`, update `exposure`, go to ISSUE.
  - ISSUE: `wr_valid=1`. On `wr_valid & wr_ready`: increment `update_count`, go to SETTLE, or to WAIT if `SETTLE_FRAMES=0`.
  - SETTLE: count `avg_valid` pulses. After SETTLE_FRAMES pulses, go to WAIT. On `enable=0`, go to IDLE immediately.
- Exposure step: `step = max(exposure>>3, 1)`.
  - Dark frame (luma below target): `exposure + step`, clamped to EXP_MAX.
  - Bright frame: `exposure - step`, clamped to EXP_MIN.
  - Arithmetic is done at EXP_BITS+1 bits, so the clamp happens before truncation and never wraps.
- If the clamped result equals the current exposure, no write is issued: go to WAIT with `locked=0`.
- `avg_valid` is ignored outside WAIT and SETTLE. A pulse coincident with the CALC→WAIT transition is lost.
- Clearing `enable` during ISSUE does not drop `wr_valid`. The handshake completes first, then the FSM goes to IDLE.
- `target` and `tolerance` are sampled only in CALC.

## Timing
- Reset values:
  - State IDLE.
  - `exposure = wr_data = EXP_INIT`.
  - `wr_valid = 0`, `locked = 0`, `busy = 0`, `update_count = 0`, settle counter 0.
- `avg_valid` at cycle T:
  - `luma` is registered at T+1 (CALC).
  - New `exposure` and `wr_valid=1` appear at T+2.
- `wr_valid`/`wr_data` stay stable until the handshake; `wr_valid` falls the cycle after acceptance.
- All outputs are registered.
- `reset` asserted mid-handshake aborts immediately; outputs return to reset values on the next edge.

## Configuration
- `ALS_AE_SAT_FAST_EN` defined:
  - If any channel average equals all-ones, CALC uses `exposure >> 1`, clamped to EXP_MIN, instead of the normal step.
  - The dead-band test is skipped for that frame.
- Macro undefined: saturated frames take the normal bright step.

## Structure
- Shared package `als_pkg` holds:
  - `ae_state_t` enum.
  - `AE_STEP_SHIFT = 3`.
  - Default exposure limits.
- One sub-module, `als_luma`: a registered 4-input sum and shift, with one cycle of latency.
- FSM, exposure arithmetic and counters live in `als_ae_ctrl`.

## Test plan
All cases use defaults, `target=512`, `tolerance=16`, `enable=1`, `wr_ready=1` unless stated.
- All channels 200, `avg_valid` → `wr_valid` 2 cycles later, `wr_data=288`, `update_count=1`.
- All channels 520 → no `wr_valid`; `locked=1`; `exposure` stays 256.
- `wr_ready` held low 5 cycles → `wr_valid`/`wr_data` stable throughout; extra `avg_valid` pulses ignored; one write counted.
- After a write, three `avg_valid` pulses with dark data → first two ignored (SETTLE), third produces the next write.
- Exposure 1120, dark frame → `wr_data=1125`. Repeat → no write, `locked=0`.
- With `ALS_AE_SAT_FAST_EN`, ch0=1023, others 600 → `wr_data=128`. Without the macro → `wr_data=224`.
